// File: rtl/reset_sequencer.sv
// Releases peripherals, memory and CPU from reset in order, gating CPU release
// on memory initialisation (with timeout); supports a software warm reset.
module reset_sequencer #(
  parameter int HOLD_CYCLES  = 4,
  parameter int STAGE_CYCLES = 8,
  parameter int MEM_TIMEOUT  = 256,
  parameter int SOFT_HOLD    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic soft_rst_req,
  input  logic mem_init_done,
  output logic periph_rst,
  output logic mem_rst,
  output logic cpu_rst,
  output logic seq_done,
  output logic timeout_err
);

  localparam int MAX_A = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
  localparam int MAX_B = (MEM_TIMEOUT > SOFT_HOLD) ? MEM_TIMEOUT : SOFT_HOLD;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] SOFT_LAST  = CW'(SOFT_HOLD - 1);

  typedef enum logic [2:0] {
    HOLD,
    PERIPH,
    MEM_WAIT,
    CPU_WAIT,
    RUN,
    SOFT
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          timeout_next;

  always_comb begin
    state_next   = state_reg;
    timeout_next = timeout_err;
    count_next   = (count_reg == '1) ? count_reg : count_reg + CW'(1);
    case (state_reg)
      HOLD:     if (count_reg == HOLD_LAST) state_next = PERIPH;
      PERIPH:   if (count_reg == STAGE_LAST) state_next = MEM_WAIT;
      MEM_WAIT: begin
        // done on the final timeout edge still counts as success
        if (mem_init_done) begin
          state_next = CPU_WAIT;
        end else if (count_reg == TMO_LAST) begin
          state_next   = CPU_WAIT;
          timeout_next = 1'b1;
        end
      end
      CPU_WAIT: if (count_reg == STAGE_LAST) state_next = RUN;
      RUN:      if (soft_rst_req) state_next = SOFT;
      SOFT:     if (count_reg == SOFT_LAST) state_next = PERIPH;
      default:  state_next = HOLD;
    endcase
    if (state_next != state_reg) count_next = '0;
  end

  // Outputs are registered from the next-state decode so they change on the
  // same edge as the state and never see an input combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= HOLD;
      count_reg   <= '0;
      timeout_err <= 1'b0;
      periph_rst  <= 1'b1;
      mem_rst     <= 1'b1;
      cpu_rst     <= 1'b1;
      seq_done    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      timeout_err <= timeout_next;
      periph_rst  <= (state_next == HOLD) || (state_next == SOFT);
      mem_rst     <= (state_next == HOLD) || (state_next == PERIPH) || (state_next == SOFT);
      cpu_rst     <= (state_next != RUN);
      seq_done    <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: randomized mem_init_done/soft_rst_req noise and timing,
// compared every cycle against a segment-timeline model of the release order.
module tb_reset_sequencer;
  localparam int H  = 4;
  localparam int S  = 8;
  localparam int T  = 256;
  localparam int SH = 16;

  logic clk = 1'b0;
  logic rst_n, soft_rst_req, mem_init_done;
  logic periph_rst, mem_rst, cpu_rst, seq_done, timeout_err;
  int   total = 0;
  int   passed = 0;
  logic sticky = 1'b0;

  reset_sequencer #(.HOLD_CYCLES(H), .STAGE_CYCLES(S), .MEM_TIMEOUT(T), .SOFT_HOLD(SH)) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .mem_init_done(mem_init_done),
    .periph_rst(periph_rst), .mem_rst(mem_rst), .cpu_rst(cpu_rst),
    .seq_done(seq_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%b exp=%b (periph,mem,cpu,done,tmo)", tag, got, exp);
  endtask

  task automatic check_order(input string tag);
    logic ok;
    ok = (cpu_rst || !mem_rst) && (mem_rst || !periph_rst);
    total++;
    assert (ok === 1'b1) passed++;
    else $error("FAIL %s order got=%b exp=1", tag, ok);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after n edges of a sequence: hold, periph stage, mem wait
  // of m edges, cpu stage, then run.
  function automatic logic [4:0] expect_at(int n, int hold, int m, logic tmo, logic prior);
    if (n < hold)              return {4'b1110, prior};
    else if (n < hold + S)     return {4'b0110, prior};
    else if (n < hold + S + m) return {4'b0010, prior};
    else if (n < hold + 2*S + m) return {4'b0010, prior | tmo};
    else                       return {4'b0001, prior | tmo};
  endfunction

  // k = MEM_WAIT edge at which done is first sampled high (k > T: never).
  task automatic run_seq(input bit cold, input int k, input int abort_at, input string tag);
    int hold, m, ph, run_len, nrun;
    logic tmo;
    if (cold) begin
      rst_n = 1'b0;
      repeat (1 + $urandom % 3) begin
        mem_init_done = 1'($urandom);
        soft_rst_req  = 1'($urandom);
        step();
        check({tag, "_rst"}, {periph_rst, mem_rst, cpu_rst, seq_done, timeout_err}, 5'b11100);
      end
      rst_n  = 1'b1;
      sticky = 1'b0;
      hold   = H;
    end else begin
      soft_rst_req = 1'b1;
      step();
      check({tag, "_softreq"}, {periph_rst, mem_rst, cpu_rst, seq_done, timeout_err}, {4'b1110, sticky});
      hold = SH;
    end
    tmo     = (k > T);
    m       = tmo ? T : k;
    ph      = hold + S;
    run_len = hold + 2*S + m;
    nrun    = 3 + $urandom % 5;
    for (int i = 0; i < run_len + nrun; i++) begin
      if (abort_at >= 0 && i == abort_at) return;
      soft_rst_req  = (i < run_len) ? 1'($urandom) : 1'b0;
      mem_init_done = (i < ph || i >= ph + m) ? 1'($urandom) : (i >= ph + k - 1);
      step();
      check($sformatf("%s_e%0d", tag, i), {periph_rst, mem_rst, cpu_rst, seq_done, timeout_err},
            expect_at(i + 1, hold, m, tmo, sticky));
      check_order(tag);
    end
    sticky = sticky | tmo;
  endtask

  initial begin
    bit cold;
    int k;
    rst_n = 1'b0;
    soft_rst_req = 1'b0;
    mem_init_done = 1'b0;
    run_seq(1, 1, -1, "cold_fast");
    run_seq(0, 6, -1, "warm_delayed");
    run_seq(0, T + 1, -1, "warm_timeout");
    run_seq(0, T, -1, "warm_boundary");
    run_seq(1, T, -1, "cold_boundary");
    run_seq(1, T + 1, H + S + 10, "cold_abort");
    run_seq(1, 3, -1, "cold_after_abort");
    for (int r = 0; r < 8; r++) begin
      cold = 1'($urandom);
      case ($urandom % 4)
        0: k = T;
        1: k = T + 1;
        default: k = 1 + $urandom % 30;
      endcase
      run_seq(cold, k, -1, $sformatf("rand%0d", r));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
